// File: rtl/wb_regfile_pkg.sv
// Shared pipeline definitions for the writeback stage: data width,
// result-select encoding and the hardwired-zero register index.
package wb_regfile_pkg;

    localparam int XLEN = 32;

    localparam logic [4:0] REG_ZERO = 5'd0;

    typedef enum logic [1:0] {
        RES_ALU = 2'b00,
        RES_MEM = 2'b01,
        RES_PC4 = 2'b10,
        RES_RSV = 2'b11
    } res_src_e;

endpackage

// File: rtl/wb_regfile_if.sv
// MEM/WB outputs, decode read ports and writeback results bundled as one bus.
// master = pipeline side driving the stage, slave = the writeback stage itself.
interface wb_regfile_if #(
    parameter int XLEN = 32,
    parameter int CNTW = 64
);

    logic            WriteW;
    logic [1:0]      ResultSrcW;
    logic [XLEN-1:0] AluResultW;
    logic [XLEN-1:0] ReadDataW;
    logic [XLEN-1:0] PCPlus4W;
    logic [4:0]      RdW;
    logic            ValidW;
    logic [4:0]      Rs1D;
    logic [4:0]      Rs2D;
    logic [XLEN-1:0] RD1D;
    logic [XLEN-1:0] RD2D;
    logic [XLEN-1:0] ResultW;
    logic [CNTW-1:0] RetireCnt;

    modport master (
        output WriteW, ResultSrcW, AluResultW, ReadDataW, PCPlus4W, RdW, ValidW,
        output Rs1D, Rs2D,
        input  RD1D, RD2D, ResultW, RetireCnt
    );

    modport slave (
        input  WriteW, ResultSrcW, AluResultW, ReadDataW, PCPlus4W, RdW, ValidW,
        input  Rs1D, Rs2D,
        output RD1D, RD2D, ResultW, RetireCnt
    );

endinterface

// File: rtl/wb_regfile_regfile_2r1w.sv
// Integer register storage: x1..x(NREGS-1) held in flops, x0 reads as zero
// and is never written. One synchronous write port, two combinational reads.
module regfile_2r1w
    import wb_regfile_pkg::REG_ZERO;
#(
    parameter int XLEN  = 32,
    parameter int NREGS = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            we,
    input  logic [4:0]      wa,
    input  logic [XLEN-1:0] wd,
    input  logic [4:0]      ra1,
    input  logic [4:0]      ra2,
    output logic [XLEN-1:0] rd1,
    output logic [XLEN-1:0] rd2
);

    logic [XLEN-1:0] regs [1:NREGS-1];

    // Clear every register on reset; otherwise commit the write unless it targets x0.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 1; i < NREGS; i++) begin
                regs[i] <= '0;
            end
        end else if (we && (wa != REG_ZERO)) begin
            regs[wa] <= wd;
        end
    end

    assign rd1 = (ra1 == REG_ZERO) ? '0 : regs[ra1];
    assign rd2 = (ra2 == REG_ZERO) ? '0 : regs[ra2];

endmodule

// File: rtl/wb_regfile.sv
// Writeback stage: picks the result, commits it to the register file,
// bypasses it to decode in the same cycle and counts retired instructions.
module wb_regfile #(
    parameter int XLEN  = wb_regfile_pkg::XLEN,
    parameter int NREGS = 32,
    parameter int CNTW  = 64
) (
    input logic        clk,
    input logic        rst,
    wb_regfile_if.slave bus
);

    import wb_regfile_pkg::*;

    logic            commit;
    logic [XLEN-1:0] result;
    logic [XLEN-1:0] rfRd1;
    logic [XLEN-1:0] rfRd2;
    logic [CNTW-1:0] retireCnt;

    // A flushed slot (ValidW=0) must never write or bypass, and x0 is never a target.
    assign commit = bus.WriteW & bus.ValidW & (bus.RdW != REG_ZERO);

    // Writeback result select; the reserved encoding yields zero.
    always_comb begin
        result = '0;
        case (res_src_e'(bus.ResultSrcW))
            RES_ALU: result = bus.AluResultW;
            RES_MEM: result = bus.ReadDataW;
            RES_PC4: result = bus.PCPlus4W;
            default: result = '0;
        endcase
    end

    regfile_2r1w #(
        .XLEN  (XLEN),
        .NREGS (NREGS)
    ) u_rf (
        .clk (clk),
        .rst (rst),
        .we  (commit),
        .wa  (bus.RdW),
        .wd  (result),
        .ra1 (bus.Rs1D),
        .ra2 (bus.Rs2D),
        .rd1 (rfRd1),
        .rd2 (rfRd2)
    );

    // Read port 1: zero in reset or for x0, else the in-flight result on a match, else storage.
    always_comb begin
        bus.RD1D = '0;
        if (!rst && (bus.Rs1D != REG_ZERO)) begin
            bus.RD1D = (commit && (bus.Rs1D == bus.RdW)) ? result : rfRd1;
        end
    end

    // Read port 2: same selection as port 1, both ports may bypass together.
    always_comb begin
        bus.RD2D = '0;
        if (!rst && (bus.Rs2D != REG_ZERO)) begin
            bus.RD2D = (commit && (bus.Rs2D == bus.RdW)) ? result : rfRd2;
        end
    end

    // Every valid instruction retires, whether or not it writes a register; wraps freely.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            retireCnt <= '0;
        end else if (bus.ValidW) begin
            retireCnt <= retireCnt + 1'b1;
        end
    end

    assign bus.ResultW   = result;
    assign bus.RetireCnt = retireCnt;

endmodule

// File: tb/tb_wb_regfile.sv
// Directed bench for wb_regfile: reset, result select, bypass, x0, flushed
// slots, retire counting (including a narrow wrapping counter) and back-to-back writes.
module tb_wb_regfile;

    import wb_regfile_pkg::*;

    logic clk;
    logic rst;
    int   total;
    int   bad;

    wb_regfile_if #(.XLEN(32), .CNTW(64)) bus ();
    wb_regfile_if #(.XLEN(32), .CNTW(4))  bus4 ();

    wb_regfile #(.XLEN(32), .NREGS(32), .CNTW(64)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    wb_regfile #(.XLEN(32), .NREGS(32), .CNTW(4)) dut4 (
        .clk (clk),
        .rst (rst),
        .bus (bus4)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic applyStimulus(input logic we, input logic valid, input logic [1:0] src,
                                 input logic [31:0] alu, input logic [31:0] mem,
                                 input logic [31:0] pc4, input logic [4:0] rd,
                                 input logic [4:0] rs1, input logic [4:0] rs2);
        bus.WriteW     = we;
        bus.ValidW     = valid;
        bus.ResultSrcW = src;
        bus.AluResultW = alu;
        bus.ReadDataW  = mem;
        bus.PCPlus4W   = pc4;
        bus.RdW        = rd;
        bus.Rs1D       = rs1;
        bus.Rs2D       = rs2;
        #1;
    endtask

    task automatic readRegs(input logic [4:0] rs1, input logic [4:0] rs2);
        applyStimulus(1'b0, 1'b0, RES_ALU, 32'h0, 32'h0, 32'h0, 5'd0, rs1, rs2);
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    initial begin
        total = 0;
        bad   = 0;
        rst   = 1'b1;
        bus4.WriteW = 1'b0; bus4.ValidW = 1'b0; bus4.ResultSrcW = 2'b00;
        bus4.AluResultW = '0; bus4.ReadDataW = '0; bus4.PCPlus4W = '0;
        bus4.RdW = '0; bus4.Rs1D = '0; bus4.Rs2D = '0;

        // Reset held: reads are zero even with a live commit request; ResultW stays combinational.
        applyStimulus(1'b1, 1'b1, RES_ALU, 32'h77, 32'h0, 32'h0, 5'd5, 5'd5, 5'd31);
        checkOutput("rst_rd1", bus.RD1D, 32'h0);
        checkOutput("rst_rd2", bus.RD2D, 32'h0);
        checkOutput("rst_cnt", bus.RetireCnt, 64'h0);
        checkOutput("rst_cnt4", {60'h0, bus4.RetireCnt}, 64'h0);
        checkOutput("rst_result", bus.ResultW, 32'h77);
        tick();
        checkOutput("rst_cnt_edge", bus.RetireCnt, 64'h0);
        rst = 1'b0;
        readRegs(5'd5, 5'd31);
        checkOutput("rst_x5_kept0", bus.RD1D, 32'h0);

        // Load data into x3.
        applyStimulus(1'b1, 1'b1, RES_MEM, 32'h11, 32'hDEADBEEF, 32'h22, 5'd3, 5'd0, 5'd0);
        checkOutput("mem_result", bus.ResultW, 32'hDEADBEEF);
        tick();
        readRegs(5'd3, 5'd0);
        checkOutput("mem_x3", bus.RD1D, 32'hDEADBEEF);
        checkOutput("cnt_1", bus.RetireCnt, 64'd1);

        // PC+4 into x4.
        applyStimulus(1'b1, 1'b1, RES_PC4, 32'h999, 32'h888, 32'h104, 5'd4, 5'd0, 5'd0);
        tick();
        readRegs(5'd4, 5'd3);
        checkOutput("pc4_x4", bus.RD1D, 32'h104);
        checkOutput("pc4_x3_kept", bus.RD2D, 32'hDEADBEEF);

        // Reserved select writes zero over x3.
        applyStimulus(1'b1, 1'b1, RES_RSV, 32'h1234, 32'h5678, 32'h9ABC, 5'd3, 5'd0, 5'd0);
        checkOutput("rsv_result", bus.ResultW, 32'h0);
        tick();
        readRegs(5'd3, 5'd0);
        checkOutput("rsv_x3", bus.RD1D, 32'h0);
        checkOutput("cnt_3", bus.RetireCnt, 64'd3);

        // Same-cycle bypass on both ports.
        applyStimulus(1'b1, 1'b1, RES_ALU, 32'h55, 32'h0, 32'h0, 5'd7, 5'd7, 5'd7);
        checkOutput("byp_rd1", bus.RD1D, 32'h55);
        checkOutput("byp_rd2", bus.RD2D, 32'h55);
        tick();
        checkOutput("cnt_4", bus.RetireCnt, 64'd4);

        // Flushed slot: no bypass, no write, no retire.
        applyStimulus(1'b1, 1'b0, RES_ALU, 32'hAA, 32'h0, 32'h0, 5'd7, 5'd7, 5'd7);
        checkOutput("flush_rd1", bus.RD1D, 32'h55);
        checkOutput("flush_rd2", bus.RD2D, 32'h55);
        checkOutput("flush_result", bus.ResultW, 32'hAA);
        tick();
        readRegs(5'd7, 5'd0);
        checkOutput("flush_x7", bus.RD1D, 32'h55);
        checkOutput("flush_cnt", bus.RetireCnt, 64'd4);

        // Write to x0 is discarded but still retires.
        applyStimulus(1'b1, 1'b1, RES_ALU, 32'hFFFFFFFF, 32'h0, 32'h0, 5'd0, 5'd0, 5'd7);
        checkOutput("x0_same_rd1", bus.RD1D, 32'h0);
        checkOutput("x0_same_rd2", bus.RD2D, 32'h55);
        tick();
        readRegs(5'd0, 5'd0);
        checkOutput("x0_after", bus.RD1D, 32'h0);
        checkOutput("x0_cnt", bus.RetireCnt, 64'd5);

        // Asynchronous reset between edges while a write to x7 is pending.
        applyStimulus(1'b1, 1'b1, RES_ALU, 32'h66, 32'h0, 32'h0, 5'd7, 5'd7, 5'd4);
        #1;
        rst = 1'b1;
        #1;
        checkOutput("arst_rd1", bus.RD1D, 32'h0);
        checkOutput("arst_rd2", bus.RD2D, 32'h0);
        checkOutput("arst_cnt", bus.RetireCnt, 64'h0);
        checkOutput("arst_result", bus.ResultW, 32'h66);
        tick();
        rst = 1'b0;
        readRegs(5'd7, 5'd4);
        checkOutput("arst_x7_lost", bus.RD1D, 32'h0);
        checkOutput("arst_x4_clr", bus.RD2D, 32'h0);
        checkOutput("arst_cnt_held", bus.RetireCnt, 64'h0);

        // Ten valid cycles, writes on even slots only to x10..x19.
        for (int i = 0; i < 10; i++) begin
            applyStimulus((i % 2) == 0, 1'b1, RES_ALU, 32'h100 + i, 32'h0, 32'h0,
                          5'(10 + i), 5'd0, 5'd0);
            tick();
        end
        checkOutput("cnt_10", bus.RetireCnt, 64'd10);
        readRegs(5'd10, 5'd11);
        checkOutput("mix_x10", bus.RD1D, 32'h100);
        checkOutput("mix_x11", bus.RD2D, 32'h0);
        readRegs(5'd18, 5'd19);
        checkOutput("mix_x18", bus.RD1D, 32'h108);
        checkOutput("mix_x19", bus.RD2D, 32'h0);

        // Bubbles add nothing and do not disturb x12.
        for (int i = 0; i < 3; i++) begin
            applyStimulus(1'b1, 1'b0, RES_ALU, 32'hBAD, 32'h0, 32'h0, 5'd12, 5'd0, 5'd0);
            tick();
        end
        readRegs(5'd12, 5'd0);
        checkOutput("bub_cnt", bus.RetireCnt, 64'd10);
        checkOutput("bub_x12", bus.RD1D, 32'h102);

        // Back-to-back writes to x9: the later one wins.
        applyStimulus(1'b1, 1'b1, RES_ALU, 32'h1, 32'h0, 32'h0, 5'd9, 5'd0, 5'd0);
        tick();
        applyStimulus(1'b1, 1'b1, RES_ALU, 32'h2, 32'h0, 32'h0, 5'd9, 5'd9, 5'd0);
        checkOutput("b2b_byp", bus.RD1D, 32'h2);
        tick();
        readRegs(5'd9, 5'd10);
        checkOutput("b2b_x9", bus.RD1D, 32'h2);
        checkOutput("b2b_x10", bus.RD2D, 32'h100);
        checkOutput("b2b_cnt", bus.RetireCnt, 64'd12);

        // Narrow counter wraps after 16 valid cycles.
        bus4.ValidW = 1'b1;
        for (int i = 0; i < 15; i++) begin
            tick();
        end
        checkOutput("wrap_15", {60'h0, bus4.RetireCnt}, 64'd15);
        tick();
        bus4.ValidW = 1'b0;
        #1;
        checkOutput("wrap_0", {60'h0, bus4.RetireCnt}, 64'd0);
        checkOutput("wrap_main_idle", bus.RetireCnt, 64'd12);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/wb_regfile.md
Name: wb_regfile

Overview:
- Writeback-stage consumer of the MEM/WB pipeline register outputs.
- Selects the writeback result and commits it to a 32x32 integer register file.
- Serves the decode stage's two read ports, with same-cycle write-to-read bypass.
- Drives ResultW to the execute-stage forwarding mux and keeps a 64-bit retired-instruction counter.

Parameters:
- XLEN, 32, data width of registers, result and read ports
- NREGS, 32, number of architectural registers (x0 hardwired to zero)
- CNTW, 64, width of the retired-instruction counter

Ports:
- clk  in  1  pipeline clock, all state updates on rising edge
- rst  in  1  asynchronous, active-high reset
- WriteW  in  1  register write enable from MEM/WB register
- ResultSrcW  in  2  result select: 00 ALU, 01 load data, 10 PC+4, 11 reserved
- AluResultW  in  XLEN  ALU result
- ReadDataW  in  XLEN  load data
- PCPlus4W  in  XLEN  return address for JAL/JALR
- RdW  in  5  destination register index
- ValidW  in  1  instruction in WB is real (0 = bubble/flushed slot)
- Rs1D  in  5  decode read port 1 index
- Rs2D  in  5  decode read port 2 index
- RD1D  out  XLEN  read port 1 data
- RD2D  out  XLEN  read port 2 data
- ResultW  out  XLEN  selected writeback value (to forwarding mux)
- RetireCnt  out  CNTW  count of retired instructions

Behaviour:
- Reset (async, rst=1): all registers x1..x31 cleared to 0, RetireCnt = 0 immediately, without waiting for a clock edge. RD1D/RD2D read 0 while rst is held. ResultW stays combinational.
- Result mux (combinational):
  - 00 -> AluResultW
  - 01 -> ReadDataW
  - 10 -> PCPlus4W
  - 11 -> 0
- Commit condition: commit = WriteW & ValidW & (RdW != 0).
- Write: on a rising clk edge with commit=1, regs[RdW] <= ResultW. A write to x0 is discarded.
- Read (combinational):
  - RDnD = 0 if RsnD == 0.
  - Otherwise RDnD = ResultW if commit and RsnD == RdW (bypass).
  - Otherwise RDnD = regs[RsnD].
  - Both ports may hit the bypass in the same cycle.
- Bypass timing: decode sees the value being written in the same cycle, so there is zero-cycle write-to-read latency. The value is architecturally visible from the next cycle.
- WriteW=1 with ValidW=0: no write and no bypass. A flushed slot never corrupts state.
- Retire counter: on a rising edge with ValidW=1, RetireCnt <= RetireCnt + 1. Independent of WriteW, so stores and branches count. Wraps modulo 2^CNTW with no saturation.
- Reset asserted mid-operation: in-flight writes are lost and all state returns to reset values. On the first edge after deassertion, normal commits resume.
- Back-to-back writes to the same Rd: the last one wins, one per cycle.

Decomposition:
- Shared package (pipeline pkg) holds:
  - ResultSrc encoding constants: RES_ALU=2'b00, RES_MEM=2'b01, RES_PC4=2'b10
  - XLEN
  - REG_ZERO=5'd0
- Natural sub-module: regfile_2r1w. Async-reset 31x XLEN storage, one write port, two read ports, x0 logic.
- wb_regfile wraps it with the result mux, bypass, commit qualification and retire counter.

Test Plan:
- Reset: hold rst, preload nothing; read Rs1D=5, Rs2D=31 -> RD1D=RD2D=0, RetireCnt=0. Assert rst asynchronously between edges -> outputs clear before the next edge.
- Result select and commit:
  - WriteW=1, ValidW=1, RdW=3, ResultSrcW=01, ReadDataW=0xDEADBEEF; next cycle Rs1D=3 -> RD1D=0xDEADBEEF.
  - Repeat with 10/PCPlus4W=0x104 -> 0x104.
  - Repeat with 11 -> 0.
- Bypass: same cycle as a write of AluResultW=0x55 to x7, set Rs1D=Rs2D=7 -> RD1D=RD2D=0x55 before the edge. With ValidW=0 -> old value.
- x0: write 0xFFFFFFFF to RdW=0, then read Rs1D=0 -> 0 both in the same cycle and afterwards. RetireCnt increments by 1.
- Retire counter:
  - 10 cycles ValidW=1 with WriteW mixed -> RetireCnt=10.
  - Bubbles (ValidW=0) add nothing.
  - Force CNTW=4 in the bench, 16 valid cycles -> wraps to 0.
- Back-to-back: write x9=0x1 then x9=0x2 on consecutive cycles -> read of x9 gives 0x2 thereafter. Reads of other registers are unaffected.
